draw_rect_char: RTL and testbench
=================================

// Module: draw_rect_char
// PURPOSE
//  Text-overlay stage of the VGA pixel pipeline. Draws a 16x16-character text box (8x16 px glyphs, 128x256 px) at
//  (XPOS,YPOS) over the incoming RGB stream. Drives the grid address to the text ROM (char_rom_16x16) and the glyph
//  line address to the font ROM. Forwards all timing signals, delay-matched to the pixel data. Sits between the
//  background/rect stages and the VGA output register.
// PARAMETERS
//  XPOS          11'd100    left edge of text box, pixels
//  YPOS          11'd50     top edge of text box, lines
//  LETTER_COLOR  12'h0f0    RGB444 colour of set glyph pixels
// PORTS
//  pclk          in   1   pixel clock
//  rst_n         in   1   asynchronous reset, active low
//  hcount_in     in   11  horizontal pixel counter
//  vcount_in     in   11  vertical line counter
//  hsync_in      in   1   horizontal sync
//  vsync_in      in   1   vertical sync
//  hblnk_in      in   1   horizontal blanking
//  vblnk_in      in   1   vertical blanking
//  rgb_in        in   12  incoming pixel colour
//  char_xy       out  8   text ROM address {row[3:0], col[3:0]}, registered
//  char_code     in   7   text ROM data; combinational from char_xy, same cycle
//  font_addr     out  11  font ROM address {char_code, line[3:0]}, combinational
//  font_pixels   in   8   font ROM data; synchronous ROM, valid 1 cycle after font_addr; bit 7 = leftmost pixel
//  hcount_out/vcount_out out 11 / hsync_out,vsync_out,hblnk_out,vblnk_out out 1 / rgb_out out 12 -- delayed copies
// BEHAVIOUR
//  - Reset (async, rst_n=0): all registered outputs and pipeline registers are 0. Deassertion is synchronous to pclk.
//  - Fixed latency 3 pclk: every *_out equals the matching *_in from 3 cycles earlier. No stalls, no handshake.
//  - Stage 0 (comb): rel_x = hcount_in - XPOS, rel_y = vcount_in - YPOS (11-bit unsigned).
//    in_rect = (hcount_in >= XPOS) && (hcount_in < XPOS+128) && (vcount_in >= YPOS) && (vcount_in < YPOS+256).
//  - Stage 1 (reg): char_xy <= in_rect ? {rel_y[7:4], rel_x[6:3]} : 8'h00; line1 <= rel_y[3:0];
//    col1 <= rel_x[2:0]; in1 <= in_rect; timing/rgb delayed 1. font_addr = {char_code, line1}.
//  - Stage 2: the font ROM registers font_pixels. Stage-2 regs hold col2, in2, and timing/rgb delayed 2.
//  - Stage 3 (reg): if (hblnk2 || vblnk2) rgb_out <= 12'h000;
//    else if (in2 && font_pixels[7-col2]) rgb_out <= LETTER_COLOR; else rgb_out <= rgb2.
//  - Boundaries:
//    - Right/bottom edges are exclusive (x = XPOS+128, y = YPOS+256 are outside).
//    - No wrap-around: hcount < XPOS underflows rel_x, but in_rect gates it off.
//    - The text ROM decodes all 256 addresses.
//  - Reset mid-frame: outputs go to 0 immediately. The first valid output is 3 cycles after release. No frame resync is needed.
// STRUCTURE
//  - vga_macros.vh (shared include): counter width 11, RGB width 12, CHAR_W=8, CHAR_H=16, grid size 16.
//  - One sub-module, delay (WIDTH, CLK_DEL), instantiated for the 38-bit timing+rgb bus:
//    22 count bits + 4 sync/blank bits + 12 rgb bits = 38; CLK_DEL=2 into stage 3.
//  - Glyph-pixel select and colour mux are inline.
// TESTING
//  1. XPOS=100, YPOS=50; hcount=100, vcount=50 -> next cycle char_xy=8'h00, font_addr={char_code,4'h0}.
//  2. hcount=227, vcount=305 -> char_xy=8'hff, line=4'hf. rgb_out uses font_pixels[0] 3 cycles later.
//  3. hcount=228 or vcount=306, rgb_in=12'h123 -> rgb_out=12'h123 after 3 cycles; char_xy=8'h00.
//  4. font model returns 8'h80, in rect, col=0 -> rgb_out=12'h0f0. Same at col=1 -> rgb_out=rgb_in delayed.
//  5. hblnk_in=1 inside rect with glyph bit set -> rgb_out=12'h000. hsync pulse at cycle t -> hsync_out at t+3.
//  6. Assert rst_n=0 mid-line -> all outputs 0 in the same cycle. Release -> outputs track inputs from cycle 3.

Source files
------------

// File: rtl/draw_rect_char_pkg.sv
// Shared VGA widths, text-box geometry and the packed timing+colour bus
// used by the text-overlay stage.
package draw_rect_char_pkg;

  localparam int CNT_W  = 11;
  localparam int RGB_W  = 12;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int GRID_N = 16;
  localparam int BOX_W  = CHAR_W * GRID_N;
  localparam int BOX_H  = CHAR_H * GRID_N;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

  localparam int VGA_BUS_W = $bits(vga_bus_t);

  // Half-open window test [lo, lo+size); one extra bit keeps lo+size from wrapping.
  function automatic logic in_span(input logic [CNT_W-1:0] pos,
                                   input logic [CNT_W-1:0] lo,
                                   input int unsigned      size);
    logic [CNT_W:0] hi;
    hi = {1'b0, lo} + (CNT_W+1)'(size);
    return (pos >= lo) && ({1'b0, pos} < hi);
  endfunction

endpackage

// File: rtl/draw_rect_char_delay.sv
// Fixed-length register pipeline; carries the timing+colour bus alongside
// the ROM lookups so every output lines up with its glyph pixel.
module draw_rect_char_delay #(
  parameter int WIDTH   = 38,
  parameter int CLK_DEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain [CLK_DEL+1];

  assign chain[0] = din;

  genvar gi;
  generate
    for (gi = 0; gi < CLK_DEL; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else begin
          q_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = q_reg;
    end
  endgenerate

  assign dout = chain[CLK_DEL];

endmodule

// File: rtl/draw_rect_char.sv
// Text-box overlay: addresses the character and font ROMs from the pixel
// counters and paints set glyph pixels over the incoming RGB stream, 3 cycles late.
module draw_rect_char
  import draw_rect_char_pkg::*;
#(
  parameter logic [CNT_W-1:0] XPOS         = 11'd100,
  parameter logic [CNT_W-1:0] YPOS         = 11'd50,
  parameter logic [RGB_W-1:0] LETTER_COLOR = 12'h0f0
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [7:0]       char_xy,
  input  logic [6:0]       char_code,
  output logic [10:0]      font_addr,
  input  logic [7:0]       font_pixels,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out
);

  // Only the low bits of the offsets are ever used, and those do not depend on
  // the upper counter bits, so the subtraction is done at the narrow width.
  logic [6:0] rel_x;
  logic [7:0] rel_y;
  logic       in_rect;

  assign rel_x   = hcount_in[6:0] - XPOS[6:0];
  assign rel_y   = vcount_in[7:0] - YPOS[7:0];
  assign in_rect = in_span(hcount_in, XPOS, BOX_W) && in_span(vcount_in, YPOS, BOX_H);

  logic [7:0] char_xy_reg;
  logic [3:0] line1_reg;
  logic [2:0] col1_reg;
  logic       in1_reg;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy_reg <= '0;
      line1_reg   <= '0;
      col1_reg    <= '0;
      in1_reg     <= 1'b0;
    end else begin
      char_xy_reg <= in_rect ? {rel_y[7:4], rel_x[6:3]} : 8'h00;
      line1_reg   <= rel_y[3:0];
      col1_reg    <= rel_x[2:0];
      in1_reg     <= in_rect;
    end
  end

  assign char_xy   = char_xy_reg;
  assign font_addr = {char_code, line1_reg};

  // Column and box flag wait one more cycle for the synchronous font ROM.
  logic [2:0] col2_reg;
  logic       in2_reg;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      col2_reg <= '0;
      in2_reg  <= 1'b0;
    end else begin
      col2_reg <= col1_reg;
      in2_reg  <= in1_reg;
    end
  end

  vga_bus_t bus_in;
  vga_bus_t bus_d2;
  logic [VGA_BUS_W-1:0] bus_d2_raw;

  always_comb begin
    bus_in        = '0;
    bus_in.hcount = hcount_in;
    bus_in.vcount = vcount_in;
    bus_in.hsync  = hsync_in;
    bus_in.vsync  = vsync_in;
    bus_in.hblnk  = hblnk_in;
    bus_in.vblnk  = vblnk_in;
    bus_in.rgb    = rgb_in;
  end

  draw_rect_char_delay #(
    .WIDTH   (VGA_BUS_W),
    .CLK_DEL (2)
  ) u_delay (
    .clk   (pclk),
    .rst_n (rst_n),
    .din   (bus_in),
    .dout  (bus_d2_raw)
  );

  assign bus_d2 = vga_bus_t'(bus_d2_raw);

  // Bit 7 of a glyph row is its leftmost pixel.
  logic     glyph_bit;
  vga_bus_t out_next;
  vga_bus_t out_reg;

  assign glyph_bit = font_pixels[3'd7 - col2_reg];

  always_comb begin
    out_next = bus_d2;
    if (bus_d2.hblnk || bus_d2.vblnk) begin
      out_next.rgb = '0;
    end else if (in2_reg && glyph_bit) begin
      out_next.rgb = LETTER_COLOR;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else begin
      out_reg <= out_next;
    end
  end

  assign hcount_out = out_reg.hcount;
  assign vcount_out = out_reg.vcount;
  assign hsync_out  = out_reg.hsync;
  assign vsync_out  = out_reg.vsync;
  assign hblnk_out  = out_reg.hblnk;
  assign vblnk_out  = out_reg.vblnk;
  assign rgb_out    = out_reg.rgb;

endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char: table vectors plus random traffic through a
// cycle-stamped scoreboard, with text/font ROM models and a mid-line reset.
module tb_draw_rect_char;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_pixels = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_rect_char dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .char_xy(char_xy), .char_code(char_code),
    .font_addr(font_addr), .font_pixels(font_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // ROM models: text ROM is combinational, font ROM registers its output.
  logic [7:0] font_mem [2048];

  function automatic logic [6:0] txt(input logic [7:0] a);
    return a[6:0] ^ {a[7], 6'h2a};
  endfunction

  always_comb char_code = txt(char_xy);
  always @(posedge pclk) font_pixels <= font_mem[font_addr];

  function automatic void model(input logic [10:0] h, input logic [10:0] v,
                                input logic hb, input logic vb, input logic [11:0] rgb,
                                output logic [7:0] xy, output logic [11:0] o);
    logic        inr;
    logic [10:0] rx, ry;
    logic [7:0]  f;
    inr = (h >= 11'd100) && (h < 11'd228) && (v >= 11'd50) && (v < 11'd306);
    rx  = h - 11'd100;
    ry  = v - 11'd50;
    xy  = inr ? {ry[7:4], rx[6:3]} : 8'h00;
    f   = font_mem[{txt(xy), ry[3:0]}];
    if (hb || vb)                    o = 12'h000;
    else if (inr && f[3'd7 - rx[2:0]]) o = 12'h0f0;
    else                             o = rgb;
  endfunction

  typedef struct {
    int          due;
    logic [7:0]  xy;
    logic [10:0] fa;
  } xy_exp_t;

  typedef struct {
    int          due;
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } out_exp_t;

  xy_exp_t  xq[$];
  out_exp_t oq[$];

  // Drive one pixel and record what must appear 1 and 3 cycles later.
  task automatic apply(input logic [10:0] h, input logic [10:0] v,
                       input logic hs, input logic vs, input logic hb, input logic vb,
                       input logic [11:0] rgb, input logic [7:0] exp_xy, input logic [11:0] exp_rgb);
    logic [10:0] ln;
    hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    ln = v - 11'd50;
    xq.push_back('{cyc + 1, exp_xy, {txt(exp_xy), ln[3:0]}});
    oq.push_back('{cyc + 3, h, v, hs, vs, hb, vb, exp_rgb});
  endtask

  task automatic apply_rand();
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb, o;
    logic [7:0]  xy;
    h   = 11'($urandom_range(240, 90));
    v   = 11'($urandom_range(320, 40));
    hs  = 1'($urandom_range(1));
    vs  = 1'($urandom_range(1));
    hb  = ($urandom_range(7) == 0);
    vb  = ($urandom_range(9) == 0);
    rgb = 12'($urandom);
    model(h, v, hb, vb, rgb, xy, o);
    apply(h, v, hs, vs, hb, vb, rgb, xy, o);
  endtask

  always @(negedge pclk) begin
    if (rst_n) begin
      while (xq.size() > 0 && xq[0].due <= cyc) begin
        xy_exp_t x;
        x = xq.pop_front();
        if (x.due < cyc) check("xy_sched", 32'(x.due), 32'(cyc));
        else begin
          check("char_xy", 32'(char_xy), 32'(x.xy));
          check("font_addr", 32'(font_addr), 32'(x.fa));
        end
      end
      while (oq.size() > 0 && oq[0].due <= cyc) begin
        out_exp_t e;
        e = oq.pop_front();
        if (e.due < cyc) check("out_sched", 32'(e.due), 32'(cyc));
        else begin
          check("rgb_out", 32'(rgb_out), 32'(e.rgb));
          check("hcount_out", 32'(hcount_out), 32'(e.h));
          check("vcount_out", 32'(vcount_out), 32'(e.v));
          check("sync_blank_out", {28'd0, hsync_out, vsync_out, hblnk_out, vblnk_out},
                {28'd0, e.hs, e.vs, e.hb, e.vb});
        end
      end
    end
  end

  typedef struct packed {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [7:0]  font;
    logic        wf;
    logic [7:0]  exp_xy;
    logic [11:0] exp_rgb;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  initial begin
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);

    //             h       v     hs    vs    hb    vb    rgb      font   wf    xy     rgb_out
    tbl[0]  = '{11'd100, 11'd50,  1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 8'h80, 1'b1, 8'h00, 12'h0f0};
    tbl[1]  = '{11'd101, 11'd50,  1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 8'h80, 1'b1, 8'h00, 12'h456};
    tbl[2]  = '{11'd227, 11'd305, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 8'h01, 1'b1, 8'hff, 12'h0f0};
    tbl[3]  = '{11'd226, 11'd305, 1'b0, 1'b0, 1'b0, 1'b0, 12'habc, 8'h01, 1'b1, 8'hff, 12'habc};
    tbl[4]  = '{11'd228, 11'd305, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 8'hff, 1'b0, 8'h00, 12'h123};
    tbl[5]  = '{11'd100, 11'd306, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 8'hff, 1'b0, 8'h00, 12'h321};
    tbl[6]  = '{11'd99,  11'd50,  1'b0, 1'b0, 1'b0, 1'b0, 12'h555, 8'hff, 1'b0, 8'h00, 12'h555};
    tbl[7]  = '{11'd100, 11'd49,  1'b0, 1'b0, 1'b0, 1'b0, 12'h666, 8'hff, 1'b0, 8'h00, 12'h666};
    tbl[8]  = '{11'd100, 11'd50,  1'b0, 1'b0, 1'b1, 1'b0, 12'h777, 8'h80, 1'b0, 8'h00, 12'h000};
    tbl[9]  = '{11'd100, 11'd50,  1'b0, 1'b0, 1'b0, 1'b1, 12'h888, 8'h80, 1'b0, 8'h00, 12'h000};
    tbl[10] = '{11'd163, 11'd133, 1'b0, 1'b0, 1'b0, 1'b0, 12'h999, 8'h01, 1'b1, 8'h57, 12'h0f0};
    tbl[11] = '{11'd164, 11'd133, 1'b0, 1'b0, 1'b0, 1'b0, 12'haaa, 8'h01, 1'b1, 8'h58, 12'haaa};
    tbl[12] = '{11'd0,   11'd0,   1'b0, 1'b0, 1'b1, 1'b1, 12'hfff, 8'h00, 1'b0, 8'h00, 12'h000};
    tbl[13] = '{11'd500, 11'd500, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0ff, 8'h00, 1'b0, 8'h00, 12'h0ff};
    tbl[14] = '{11'd501, 11'd500, 1'b0, 1'b1, 1'b0, 1'b0, 12'hf0f, 8'h00, 1'b0, 8'h00, 12'hf0f};
    tbl[15] = '{11'd502, 11'd500, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00f, 8'h00, 1'b0, 8'h00, 12'h00f};

    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].wf) begin
        logic [10:0] ln;
        ln = tbl[i].v - 11'd50;
        font_mem[{txt(tbl[i].exp_xy), ln[3:0]}] = tbl[i].font;
      end
    end

    repeat (3) @(posedge pclk);
    #1;
    check("reset_char_xy", 32'(char_xy), 32'h0);
    check("reset_rgb_out", 32'(rgb_out), 32'h0);
    check("reset_counts", {10'd0, hcount_out, vcount_out}, 32'h0);
    check("reset_sync_blank", {28'd0, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'h0);

    @(negedge pclk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge pclk);
      #1;
      apply(tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb,
            tbl[i].rgb, tbl[i].exp_xy, tbl[i].exp_rgb);
      $display("vec %0d: h=%0d v=%0d rgb=%h -> xy=%h rgb_out=%h", i, tbl[i].h, tbl[i].v,
               tbl[i].rgb, tbl[i].exp_xy, tbl[i].exp_rgb);
    end

    for (int i = 0; i < 300; i++) begin
      @(posedge pclk);
      #1 apply_rand();
    end

    // Asynchronous reset in the middle of a line, then restart.
    @(posedge pclk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_char_xy", 32'(char_xy), 32'h0);
    check("midreset_rgb_out", 32'(rgb_out), 32'h0);
    check("midreset_counts", {10'd0, hcount_out, vcount_out}, 32'h0);
    check("midreset_sync_blank", {28'd0, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'h0);
    xq.delete();
    oq.delete();
    hcount_in = 11'd120; vcount_in = 11'd70; rgb_in = 12'h5a5;
    @(negedge pclk);
    @(negedge pclk);
    #1 rst_n = 1'b1;
    apply(11'd100, 11'd50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 8'h00, 12'h0f0);
    $display("release: first pixel driven at cycle %0d", cyc);
    for (int k = 1; k <= 2; k++) begin
      @(posedge pclk);
      #1 apply_rand();
      @(negedge pclk);
      check("release_rgb_zero", 32'(rgb_out), 32'h0);
      check("release_hcount_zero", 32'(hcount_out), 32'h0);
    end

    for (int i = 0; i < 40; i++) begin
      @(posedge pclk);
      #1 apply_rand();
    end

    repeat (6) @(posedge pclk);
    @(negedge pclk);
    #1 check("scoreboard_drain", 32'(xq.size() + oq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
